// File: rtl/i2c_txn_arbiter_if.sv
// Requester and engine-side signals of the I2C transaction arbiter.
// slave = arbiter view, master = requesters plus engine (the environment).
interface i2c_txn_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             req_rw;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [1:0]                     rsp_err;
  logic [DATA_W-1:0]              rsp_rdata;
  logic                           eng_cmd_valid;
  logic                           eng_cmd_ready;
  logic                           eng_rw;
  logic [ADDR_W-1:0]              eng_addr;
  logic [DATA_W-1:0]              eng_wdata;
  logic                           eng_done;
  logic                           eng_nack;
  logic [DATA_W-1:0]              eng_rdata;
  logic                           eng_abort;

  modport slave (
    input  req_valid, req_rw, req_addr, req_wdata,
    input  eng_cmd_ready, eng_done, eng_nack, eng_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
    output eng_cmd_valid, eng_rw, eng_addr, eng_wdata, eng_abort
  );

  modport master (
    output req_valid, req_rw, req_addr, req_wdata,
    output eng_cmd_ready, eng_done, eng_nack, eng_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
    input  eng_cmd_valid, eng_rw, eng_addr, eng_wdata, eng_abort
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one byte-level I2C master engine between NUM_REQ
// requesters, with per-transaction timeout and response routing.
module i2c_txn_arbiter #(
  parameter  int NUM_REQ = 4,
  parameter  int ADDR_W  = 7,
  parameter  int DATA_W  = 8,
  parameter  int TIMEOUT = 1024,
  localparam int GID_W   = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  i2c_txn_arbiter_if.slave  bus,
  output logic              busy_o,
  output logic [GID_W-1:0]  grant_id_o
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [GID_W-1:0] LAST_ID = GID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [GID_W-1:0]    ptr_q, ptr_d;
  logic [GID_W-1:0]    gid_q, gid_d;
  logic                rw_q, rw_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                win_vld;
  logic [GID_W-1:0]    win_idx;
  logic                to_hit;
  int                  scan;

  // Scan downward in offset so the requester closest above the pointer wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    scan    = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan = int'(ptr_q) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      if (bus.req_valid[GID_W'(scan)]) begin
        win_vld = 1'b1;
        win_idx = GID_W'(scan);
      end
    end
  end

  assign to_hit = (cnt_q == TO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_ISSUE;
          gid_d   = win_idx;
          rw_d    = bus.req_rw[win_idx];
          addr_d  = bus.req_addr[win_idx];
          wdata_d = bus.req_wdata[win_idx];
          ptr_d   = (win_idx == LAST_ID) ? '0 : win_idx + 1'b1;
          cnt_d   = '0;
        end
      end
      S_ISSUE: begin
        cnt_d = cnt_q + 1'b1;
        // A timeout here takes priority: the abort pulse cancels any command taken this cycle.
        if (to_hit) begin
          err_d   = 2'b10;
          rdata_d = '0;
          state_d = S_RESP;
        end else if (bus.eng_cmd_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus.eng_done) begin
          err_d   = bus.eng_nack ? 2'b01 : 2'b00;
          rdata_d = (rw_q && !bus.eng_nack) ? bus.eng_rdata : '0;
          state_d = S_RESP;
        end else if (to_hit) begin
          err_d   = 2'b10;
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      gid_q   <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    bus.req_ready     = '0;
    bus.rsp_valid     = '0;
    bus.eng_cmd_valid = 1'b0;
    bus.eng_abort     = 1'b0;
    busy_o            = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE:  if (win_vld) bus.req_ready[win_idx] = 1'b1;
      S_ISSUE: begin
        bus.eng_cmd_valid = 1'b1;
        bus.eng_abort     = to_hit;
      end
      S_WAIT:  bus.eng_abort = to_hit && !bus.eng_done;
      S_RESP:  bus.rsp_valid[gid_q] = 1'b1;
      default: ;
    endcase
  end

  assign bus.eng_rw    = rw_q;
  assign bus.eng_addr  = addr_q;
  assign bus.eng_wdata = wdata_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = rdata_q;
  assign grant_id_o    = gid_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter: stimulus pushes expected grants, commands
// and responses; one negedge monitor pops and compares them as the DUT presents them.
module tb_i2c_txn_arbiter;
  localparam int NR = 4;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       busy;
  logic [1:0] grant_id;

  always #5 clk = ~clk;

  i2c_txn_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus();

  i2c_txn_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .busy_o     (busy),
    .grant_id_o (grant_id)
  );

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  typedef struct {
    logic [NR-1:0] oh;
    logic [1:0]    err;
    logic [DW-1:0] rdata;
  } rsp_t;

  cmd_t exp_cmd[$];
  rsp_t exp_rsp[$];
  int   exp_gnt[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int issue_cyc = 0;
  int abort_cnt = 0;
  int abort_off = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compare whatever the DUT presents this cycle against the queues.
  initial begin
    cmd_t c;
    rsp_t r;
    int   g;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (|bus.req_ready) begin
          if (exp_gnt.size() == 0) check("grant_unexpected", 32'(bus.req_ready), 0);
          else begin
            g = exp_gnt.pop_front();
            check("grant_onehot", 32'(bus.req_ready), 32'(NR'(1) << g));
          end
        end
        if (bus.eng_cmd_valid) begin
          if (exp_cmd.size() == 0) check("cmd_unexpected", 32'(bus.eng_cmd_valid), 0);
          else begin
            c = exp_cmd[0];
            check("eng_rw", 32'(bus.eng_rw), 32'(c.rw));
            check("eng_addr", 32'(bus.eng_addr), 32'(c.addr));
            check("eng_wdata", 32'(bus.eng_wdata), 32'(c.wdata));
            if (bus.eng_cmd_ready || bus.eng_abort) void'(exp_cmd.pop_front());
          end
          if (!prev_valid) issue_cyc = cyc;
        end
        if (|bus.rsp_valid) begin
          if (exp_rsp.size() == 0) check("rsp_unexpected", 32'(bus.rsp_valid), 0);
          else begin
            r = exp_rsp.pop_front();
            check("rsp_valid", 32'(bus.rsp_valid), 32'(r.oh));
            check("rsp_err", 32'(bus.rsp_err), 32'(r.err));
            check("rsp_rdata", 32'(bus.rsp_rdata), 32'(r.rdata));
          end
        end
        if (bus.eng_abort) begin
          abort_cnt++;
          abort_off = cyc - issue_cyc;
        end
        prev_valid = bus.eng_cmd_valid;
      end
    end
  end

  task automatic set_req(input int id, input int rw, input int a, input int d);
    bus.req_rw[id]    = 1'(rw);
    bus.req_addr[id]  = AW'(a);
    bus.req_wdata[id] = DW'(d);
    bus.req_valid[id] = 1'b1;
  endtask

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  // Plays the engine for one transaction. rdy/dn < 0 means never respond.
  // drop: 0 release own request, 1 keep all, 2 release all.
  task automatic serve(input int id, input int rw, input int a, input int d,
                       input int rdy, input int dn, input int nack, input int rd,
                       input int e_err, input int e_rd, input int drop);
    cmd_t c;
    rsp_t r;
    int   n;
    c.rw = 1'(rw); c.addr = AW'(a); c.wdata = DW'(d);
    r.oh = NR'(1) << id; r.err = 2'(e_err); r.rdata = DW'(e_rd);
    exp_gnt.push_back(id);
    exp_cmd.push_back(c);
    exp_rsp.push_back(r);
    n = 0;
    while (!bus.eng_cmd_valid && n < 20) begin wait_cycle(); n++; end
    check("issue_start", 32'(bus.eng_cmd_valid), 1);
    check("grant_id", 32'(grant_id), 32'(id));
    check("busy_issue", 32'(busy), 1);
    if (drop == 0) bus.req_valid[id] = 1'b0;
    else if (drop == 2) bus.req_valid = '0;
    if (rdy >= 0) begin
      repeat (rdy) wait_cycle();
      bus.eng_cmd_ready = 1'b1;
      wait_cycle();
      bus.eng_cmd_ready = 1'b0;
      if (dn >= 0) begin
        repeat (dn) wait_cycle();
        bus.eng_done  = 1'b1;
        bus.eng_nack  = 1'(nack);
        bus.eng_rdata = DW'(rd);
        wait_cycle();
        bus.eng_done  = 1'b0;
        bus.eng_nack  = 1'b0;
        bus.eng_rdata = '0;
        check("rsp_latency", 32'(|bus.rsp_valid), 1);
        return;
      end
    end
    n = 0;
    while (!(|bus.rsp_valid) && n < 40) begin wait_cycle(); n++; end
    check("rsp_after_timeout", 32'(|bus.rsp_valid), 1);
  endtask

  initial begin
    cmd_t c;
    int   n;
    bus.req_valid = '0; bus.req_rw = '0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.eng_cmd_ready = 1'b0; bus.eng_done = 1'b0; bus.eng_nack = 1'b0; bus.eng_rdata = '0;
    repeat (3) wait_cycle();
    check("rst_busy", 32'(busy), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_cmd_valid", 32'(bus.eng_cmd_valid), 0);
    check("rst_abort", 32'(bus.eng_abort), 0);
    check("rst_eng_fields", 32'({bus.eng_rw, bus.eng_addr, bus.eng_wdata}), 0);
    check("rst_rsp", 32'({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata}), 0);
    check("rst_req_ready", 32'(bus.req_ready), 0);
    rst_n = 1'b1;
    wait_cycle();

    // Single write; read data on the engine bus must not leak into a write response.
    set_req(2, 0, 'h50, 'hA5);
    serve(2, 0, 'h50, 'hA5, 3, 2, 0, 'hEE, 0, 0, 0);
    // Pointer now 3: a lone requester 3 leaves it at 0.
    set_req(3, 0, 'h11, 'h22);
    serve(3, 0, 'h11, 'h22, 0, 0, 0, 0, 0, 0, 0);

    // Round robin with everyone pending.
    for (int i = 0; i < NR; i++) set_req(i, 0, 'h10 + i, 'h20 + i);
    for (int k = 0; k < 5; k++)
      serve(k % NR, 0, 'h10 + (k % NR), 'h20 + (k % NR), 1, 2, 0, 0, 0, 0, (k == 4) ? 2 : 1);

    // Read NACK zeroes the returned byte.
    set_req(0, 1, 'h3C, 0);
    serve(0, 1, 'h3C, 0, 2, 3, 1, 'hFF, 1, 0, 0);

    // Timeout in WAIT: engine accepts but never completes.
    abort_cnt = 0;
    set_req(1, 0, 'h2A, 'h99);
    serve(1, 0, 'h2A, 'h99, 2, -1, 0, 0, 2, 0, 0);
    check("wait_to_abort_count", 32'(abort_cnt), 1);
    check("wait_to_abort_offset", 32'(abort_off), 15);
    wait_cycle();
    check("idle_after_timeout", 32'(busy), 0);

    // Timeout in ISSUE: engine never takes the command.
    abort_cnt = 0;
    set_req(2, 1, 'h55, 0);
    serve(2, 1, 'h55, 0, -1, -1, 0, 0, 2, 0, 0);
    check("issue_to_abort_count", 32'(abort_cnt), 1);
    check("issue_to_abort_offset", 32'(abort_off), 15);

    // eng_done lands on the timeout compare cycle: done wins.
    abort_cnt = 0;
    set_req(3, 1, 'h44, 0);
    serve(3, 1, 'h44, 0, 2, 12, 0, 'h5A, 0, 'h5A, 0);
    check("tie_no_abort", 32'(abort_cnt), 0);
    repeat (3) wait_cycle();
    check("rdata_hold", 32'(bus.rsp_rdata), 'h5A);
    check("err_hold", 32'(bus.rsp_err), 0);

    // Reset while in WAIT (pointer was 2 after this grant).
    set_req(1, 0, 'h66, 'h77);
    c.rw = 1'b0; c.addr = AW'('h66); c.wdata = DW'('h77);
    exp_gnt.push_back(1);
    exp_cmd.push_back(c);
    n = 0;
    while (!bus.eng_cmd_valid && n < 20) begin wait_cycle(); n++; end
    check("h_issue", 32'(bus.eng_cmd_valid), 1);
    bus.req_valid = '0;
    bus.eng_cmd_ready = 1'b1;
    wait_cycle();
    bus.eng_cmd_ready = 1'b0;
    wait_cycle();
    check("h_busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("h_rst_busy", 32'(busy), 0);
    check("h_rst_cmd_valid", 32'(bus.eng_cmd_valid), 0);
    check("h_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    check("h_rst_eng_addr", 32'(bus.eng_addr), 0);
    check("h_rst_grant_id", 32'(grant_id), 0);
    check("h_rst_abort", 32'(bus.eng_abort), 0);
    wait_cycle();
    wait_cycle();
    rst_n = 1'b1;
    // Pointer back at 0: requester 1 wins over 3.
    set_req(1, 1, 'h12, 0);
    set_req(3, 0, 'h34, 'h56);
    serve(1, 1, 'h12, 0, 1, 1, 0, 'hC3, 0, 'hC3, 0);
    serve(3, 0, 'h34, 'h56, 0, 0, 0, 0, 0, 0, 0);

    repeat (4) wait_cycle();
    check("queues_drained", 32'(exp_gnt.size() + exp_cmd.size() + exp_rsp.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end
endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Round-robin arbiter and transaction sequencer that shares one byte-level I2C master engine between NUM_REQ requesters.
- Each requester submits a single-byte read or write to a 7-bit target address. The block serialises these requests onto the engine's command handshake.
- It supervises each transaction with a timeout and routes the completion status and read data back to the originating requester.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ADDR_W, 7, I2C target address width
DATA_W, 8, data byte width
TIMEOUT, 1024, max cycles from entering ISSUE to eng_done before abort (>=4)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NUM_REQ  per-requester request pending
req_ready  out  NUM_REQ  one-hot accept, combinational, asserted only in IDLE
req_rw  in  NUM_REQ  1=read, 0=write
req_addr  in  NUM_REQ*ADDR_W  packed target addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write bytes
rsp_valid  out  NUM_REQ  one-hot one-cycle completion pulse
rsp_err  out  2  00 ok, 01 NACK, 10 timeout; valid with rsp_valid
rsp_rdata  out  DATA_W  read byte; valid with rsp_valid when rw=1 and err=00
eng_cmd_valid  out  1  command to engine
eng_cmd_ready  in  1  engine accepts command
eng_rw  out  1  latched rw
eng_addr  out  ADDR_W  latched address
eng_wdata  out  DATA_W  latched write byte
eng_done  in  1  engine transaction complete pulse
eng_nack  in  1  target NACKed; valid with eng_done
eng_rdata  in  DATA_W  read byte; valid with eng_done
eng_abort  out  1  one-cycle abort pulse to engine
busy  out  1  high in any state except IDLE
grant_id  out  clog2(NUM_REQ)  index of current/last granted requester

Behaviour:
- Reset values: state IDLE; round-robin pointer 0; all outputs 0; latched rw/addr/wdata/rdata 0; timeout counter 0.
- States:
  - IDLE: winner = first i with req_valid[i], scanning from pointer upward with wrap. If a winner exists: req_ready[winner]=1 in the same cycle; latch rw/addr/wdata and grant_id; pointer <= (winner+1) mod NUM_REQ; counter <= 0; go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: eng_cmd_valid=1; eng_* fields stable from the latches. On eng_cmd_ready go to WAIT. Counter increments every cycle. eng_done is ignored here.
  - WAIT: counter increments. On eng_done: latch eng_rdata and eng_nack, go to RESP. If counter == TIMEOUT-1 and no eng_done: eng_abort=1 for this cycle, err <= 10, go to RESP.
  - RESP: rsp_valid[grant_id]=1 for exactly one cycle; rsp_err and rsp_rdata are driven from registers; then go to IDLE.
- Timeout while in ISSUE (counter reaches TIMEOUT-1 before eng_cmd_ready): pulse eng_abort, err=10, go to RESP.
- eng_done in the same cycle as the timeout compare: eng_done wins, no abort.
- Latency:
  - accept to eng_cmd_valid: 1 cycle.
  - eng_done to rsp_valid: 1 cycle.
  - rsp_valid to next accept: 1 cycle. The RESP cycle is followed by IDLE, so the minimum transaction spacing is 4 cycles.
- Requests:
  - Dropping req_valid before acceptance is legal; no grant occurs.
  - The block ignores a granted requester's inputs after acceptance; the latched copy is used.
  - A requester may reassert in the cycle after its rsp_valid.
- rsp_rdata holds its value until the next RESP. It is zero-driven when err != 00 or rw=0.
- Starvation-free: with all requesters valid, grants rotate 0,1,..,NUM_REQ-1,0.
- Asynchronous reset mid-transaction returns to reset values immediately. No eng_abort is issued because the engine shares rst_n.

Test Plan:
1. Single write: req_valid[2]=1, addr=0x50, wdata=0xA5, eng_cmd_ready after 3 cycles, eng_done nack=0 -> req_ready=0b0100 in cycle 0; eng_addr=0x50, eng_wdata=0xA5 stable until ready; rsp_valid=0b0100, rsp_err=00.
2. Read NACK: req 0 rw=1, addr=0x3C; eng_done with eng_nack=1, eng_rdata=0xFF -> rsp_valid=0b0001, rsp_err=01, rsp_rdata=0x00.
3. Round-robin: all four req_valid held high, engine completes each in 5 cycles -> grant order 0,1,2,3,0; no requester is granted twice in a row.
4. Timeout with TIMEOUT=16: engine never asserts eng_done -> eng_abort pulses exactly once, 15 cycles after entering ISSUE; rsp_err=10; returns to IDLE.
5. Tie case: eng_done in the same cycle as the counter reaching TIMEOUT-1 -> no eng_abort; rsp_err=00.
6. Reset mid-WAIT: deassert rst_n -> busy, eng_cmd_valid, rsp_valid at 0 immediately. After release, req_valid[1] -> granted first (pointer=0, scanning finds 1).
